mult_div_sequencer: RTL and testbench



---
 rtl/mips_pkg.sv | 44 ++++
 rtl/mult_div_sequencer_alu.sv | 37 +++
 rtl/mult_div_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide path.
//   alu_op_t    : ALU operation codes understood by the alu block
//   md_op_t     : multiply/divide operation select (bit 1 = divide, bit 0 = signed)
//   seq_state_t : sequencer states
//   magnitude() : two's-complement absolute value; 0x80000000 maps to 2^31
package mips_pkg;

    typedef enum logic [3:0] {
        ADD      = 4'b0000,
        SUBTRACT = 4'b0010,
        BITAND   = 4'b0100,
        BITOR    = 4'b0101,
        BITXOR   = 4'b0110,
        BITNOR   = 4'b0111,
        SLL      = 4'b1000,
        SRL      = 4'b1001,
        SLT      = 4'b1010,
        SLTU     = 4'b1011,
        SRA      = 4'b1100,
        LUI      = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        MULTU = 2'b00,
        MULT  = 2'b01,
        DIVU  = 2'b10,
        DIV   = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } seq_state_t;

    localparam logic [4:0] LAST_ITER = 5'd31;

    // Reinterpreted as unsigned, -2^31 negates to itself, which is exactly 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_sequencer_alu.sv
// Combinational 32-bit ALU.
//   op_i     : operation code (alu_op_t)
//   a_i, b_i : operands; shifts move b_i by a_i[4:0]
//   result_o : operation result
//   zero_o   : result_o == 0
module alu
    import mips_pkg::*;
(
    input  alu_op_t     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        unique case (op_i)
            ADD:      result_o = a_i + b_i;
            SUBTRACT: result_o = a_i - b_i;
            BITAND:   result_o = a_i & b_i;
            BITOR:    result_o = a_i | b_i;
            BITXOR:   result_o = a_i ^ b_i;
            BITNOR:   result_o = ~(a_i | b_i);
            SLL:      result_o = b_i << a_i[4:0];
            SRL:      result_o = b_i >> a_i[4:0];
            SRA:      result_o = $signed(b_i) >>> a_i[4:0];
            SLT:      result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            SLTU:     result_o = {31'd0, a_i < b_i};
            LUI:      result_o = {b_i[15:0], 16'd0};
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle multiply/divide unit (MULT, MULTU, DIV, DIVU) producing HI/LO.
// Runs a 32-iteration shift-add multiply or restoring divide on operand
// magnitudes, one ALU ADD/SUBTRACT per iteration, then applies the sign fix.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request strobe, sampled only while busy=0
//   op         : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_val     : multiplicand / dividend
//   rt_val     : multiplier / divisor
//   busy       : operation in progress (cycle after accept through DONE)
//   done       : one-cycle pulse, hi/lo valid from this cycle on
//   hi, lo     : product[63:32]/[31:0] or remainder/quotient
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0; operands are captured on that edge. There is no back-pressure and
// no queueing: start while busy=1 is dropped. done pulses exactly 34 cycles
// after acceptance, and hi/lo hold until the next operation's FIX cycle.
module mult_div_sequencer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    seq_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    md_op_t      op_q, op_d;
    logic [31:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [31:0] acc_hi_q, acc_hi_d;  // product high / partial remainder
    logic [31:0] acc_lo_q, acc_lo_d;  // multiplier shifting out / quotient shifting in
    logic [31:0] rs_raw_q, rs_raw_d;  // original dividend, returned on divide-by-zero
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        div0_q, div0_d;

    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;

    logic        is_div;
    logic        in_signed;
    logic [31:0] r_shift;
    logic        carry;
    logic        take_sub;
    logic [63:0] acc_neg;

    alu u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    assign is_div    = op_q[1];
    assign in_signed = op[0];
    assign r_shift   = {acc_hi_q[30:0], acc_lo_q[31]};
    // Unsigned wrap of acc_hi + multiplicand means a carry out of bit 31.
    assign carry     = (alu_result < acc_hi_q);
    // acc_hi[31] is the bit shifted out of r_shift; if set, r' is really
    // 33 bits wide and always exceeds a 32-bit divisor.
    assign take_sub  = acc_hi_q[31] | (r_shift >= opnd_q);
    assign acc_neg   = ~{acc_hi_q, acc_lo_q} + 64'd1;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        alu_op = ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (state_q == RUN) begin
            alu_b = opnd_q;
            if (is_div) begin
                alu_op = SUBTRACT;
                alu_a  = r_shift;
            end else begin
                alu_op = ADD;
                alu_a  = acc_hi_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        rs_raw_d  = rs_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    op_d      = md_op_t'(op);
                    acc_hi_d  = '0;
                    rs_raw_d  = rs_val;
                    quo_neg_d = in_signed & (rs_val[31] ^ rt_val[31]);
                    rem_neg_d = in_signed & rs_val[31];
                    div0_d    = op[1] & (rt_val == 32'd0);
                    if (op[1]) begin
                        acc_lo_d = magnitude(rs_val, in_signed);
                        opnd_d   = magnitude(rt_val, in_signed);
                    end else begin
                        acc_lo_d = magnitude(rt_val, in_signed);
                        opnd_d   = magnitude(rs_val, in_signed);
                    end
                end
            end
            RUN: begin
                if (is_div) begin
                    acc_hi_d = take_sub ? alu_result : r_shift;
                    acc_lo_d = {acc_lo_q[30:0], take_sub};
                end else if (acc_lo_q[0]) begin
                    acc_hi_d = {carry, alu_result[31:1]};
                    acc_lo_d = {alu_result[0], acc_lo_q[31:1]};
                end else begin
                    acc_hi_d = {1'b0, acc_hi_q[31:1]};
                    acc_lo_d = {acc_hi_q[0], acc_lo_q[31:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            FIX: begin
                state_d = DONE;
                if (!is_div) begin
                    {hi_d, lo_d} = quo_neg_q ? acc_neg : {acc_hi_q, acc_lo_q};
                end else if (div0_q) begin
                    hi_d = rs_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    lo_d = quo_neg_q ? acc_neg[31:0] : acc_lo_q;
                    hi_d = rem_neg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MULTU;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            rs_raw_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            rs_raw_q  <= rs_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer. Expected {hi,lo} values come
// from a behavioural model built on native 64-bit and signed arithmetic and
// are queued when a request is driven, then popped when done is seen.
module tb_mult_div_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    mult_div_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        model = '0;
        case (o)
            2'b00: model = {32'd0, a} * {32'd0, b};
            2'b01: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                model = sp;
            end
            2'b10: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else            model = {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) begin
                    model = {a, 32'hFFFF_FFFF};
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    model = {sr, sq};
                end
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge one cycle after
    // the accepting rising edge (the first busy cycle).
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 100) $display("FAIL start_idle: busy=%b after %0d cycles, want 0", busy, guard);
        else n_pass++;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start  = 1'b0;
        op     = 2'($urandom_range(0, 3));
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    // Counts cycles from acceptance (first busy cycle = 1) until done.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
    endtask

    task automatic test_directed;
        logic [1:0]  t_op[7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
        logic [31:0] t_a[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd100,
                                 32'hFFFF_FFF9, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [31:0] t_b[7]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd7,
                                 32'd2, 32'd0, 32'd0};
        int cyc;
        logic [63:0] e;
        for (int i = 0; i < 7; i++) begin
            start_op(t_op[i], t_a[i], t_b[i]);
            wait_done(cyc);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (cyc !== 34) $display("FAIL directed%0d_latency: got %0d want 34", i, cyc);
            else n_pass++;
            n_checks++;
            if ({hi, lo} !== e) $display("FAIL directed%0d_result: got %h want %h", i, {hi, lo}, e);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b1) $display("FAIL directed%0d_busy_in_done: got %b want 1", i, busy);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) $display("FAIL directed%0d_done_pulse: got %b want 0", i, done);
            else n_pass++;
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        int n_done;
        logic [63:0] prev;
        logic [63:0] e;
        prev   = {hi, lo};
        n_done = 0;
        start_op(2'b10, 32'd1000, 32'd33);
        cyc = 1;
        while (cyc < 35) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) begin
                start = 1'b1; op = 2'b00; rs_val = 32'd5; rt_val = 32'd9;
                n_checks++;
                if ({hi, lo} !== prev) $display("FAIL ignore_hold: got %h want %h", {hi, lo}, prev);
                else n_pass++;
            end
            if (cyc == 11) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (cyc !== 34) $display("FAIL ignore_latency: got %0d want 34", cyc); else n_pass++;
                n_checks++;
                if ({hi, lo} !== e) $display("FAIL ignore_result: got %h want %h", {hi, lo}, e);
                else n_pass++;
            end
        end
        n_checks++; if (n_done !== 1) $display("FAIL ignore_done_count: got %0d want 1", n_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ignore_idle_t35: got %b want 0", busy); else n_pass++;
        // Back-to-back: request at T0+35.
        start_op(2'b01, 32'hFFFF_FFF7, 32'd4);
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", busy); else n_pass++;
        wait_done(cyc);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_checks++; if (cyc !== 34) $display("FAIL b2b_latency: got %0d want 34", cyc); else n_pass++;
        n_checks++;
        if ({hi, lo} !== e) $display("FAIL b2b_result: got %h want %h", {hi, lo}, e); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int cyc;
        int n_done;
        logic [63:0] e;
        start_op(2'b01, 32'd123456, 32'hFFFF_FCEB);
        for (int i = 2; i <= 20; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL abort_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL abort_lo: got %h want 0", lo); else n_pass++;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_checks++; if (n_done !== 0) $display("FAIL abort_no_done: got %0d want 0", n_done); else n_pass++;
        start_op(2'b00, 32'd6, 32'd7);
        wait_done(cyc);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_checks++; if (cyc !== 34) $display("FAIL after_abort_latency: got %0d want 34", cyc); else n_pass++;
        n_checks++;
        if ({hi, lo} !== e) $display("FAIL after_abort_result: got %h want %h", {hi, lo}, e); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random;
        int cyc;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;
        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
            if (i % 3 == 1) b = b >> $urandom_range(8, 28);
            if (o == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            start_op(o, a, b);
            wait_done(cyc);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (cyc !== 34) $display("FAIL random%0d_latency: got %0d want 34", i, cyc); else n_pass++;
            n_checks++;
            if ({hi, lo} !== e)
                $display("FAIL random%0d_result: op=%0d a=%h b=%h got %h want %h", i, o, a, b, {hi, lo}, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
